// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizes for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin search: first set request at or after i_rr_ptr, wrapping
// from NUM_REQ-1 back to 0 (also for non-power-of-2 NUM_REQ).
module rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
  output logic                       o_found,
  output logic [$clog2(NUM_REQ)-1:0] o_winner
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  function automatic int unsigned wrap_idx(input logic [IDX_W-1:0] base,
                                           input int unsigned       offs);
    int unsigned s;
    s = 32'(base) + offs;
    return (s >= NUM_REQ) ? (s - NUM_REQ) : s;
  endfunction

  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!o_found && i_req[IDX_W'(wrap_idx(i_rr_ptr, k))]) begin
        o_found  = 1'b1;
        o_winner = IDX_W'(wrap_idx(i_rr_ptr, k));
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ
// producers; ack/write are combinational so fifo_full gates them same-cycle.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = fifo_arb_pkg::DATA_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  input  logic                        fifo_full,
  output logic                        fifo_write_en,
  output logic [DATA_W-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic                        busy
);

  localparam int unsigned      IDX_W     = $clog2(NUM_REQ);
  localparam int unsigned      CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt, w_beat_inc;
  logic [IDX_W-1:0] w_winner;
  logic             w_found;
  logic             w_owner_req;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_winner (w_winner)
  );

  assign w_owner_req = req[r_owner];
  assign w_beat_inc  = r_beat_cnt + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    unique case (r_state)
      ARB_IDLE: begin
        if (!fifo_full && w_found) begin
          w_owner_nxt    = w_winner;
          w_beat_cnt_nxt = CNT_W'(1);
          if (MAX_BURST == 1) w_rr_ptr_nxt = next_idx(w_winner);
          else                w_state_nxt  = ARB_BURST;
        end
      end
      ARB_BURST: begin
        // Owner dropping req costs one dead cycle; a full FIFO just stalls.
        if (!w_owner_req) begin
          w_state_nxt  = ARB_IDLE;
          w_rr_ptr_nxt = next_idx(r_owner);
        end else if (!fifo_full) begin
          w_beat_cnt_nxt = w_beat_inc;
          if (w_beat_inc == LAST_BEAT) begin
            w_state_nxt  = ARB_IDLE;
            w_rr_ptr_nxt = next_idx(r_owner);
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    ack          = '0;
    fifo_data_in = '0;
    if (!reset) begin
      if (r_state == ARB_IDLE) begin
        if (!fifo_full && w_found) ack[w_winner] = 1'b1;
      end else if (w_owner_req && !fifo_full) begin
        ack[r_owner] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ack[i]) fifo_data_in = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign fifo_write_en = |ack;
  assign busy          = !reset && (r_state == ARB_BURST);
  assign owner         = r_owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected beats queued at stimulus time,
// popped whenever the arbiter writes; a small FIFO fill model for the full test.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned MB    = 4;
  localparam int unsigned DEPTH = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic               full_drv;
  logic               w_full;
  logic               wr;
  logic [DW-1:0]      din;
  logic [1:0]         owner;
  logic               busy;
  logic               use_model;
  logic               rd;
  int unsigned        fcnt = 0;

  int          checks   = 0;
  int          failures = 0;
  int          acked    = -1;
  int unsigned seq  [NREQ];
  int unsigned pseq [NREQ];

  typedef struct {
    int unsigned   idx;
    logic [DW-1:0] data;
  } beat_t;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clock         (clk),
    .reset         (rst),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .fifo_full     (w_full),
    .fifo_write_en (wr),
    .fifo_data_in  (din),
    .owner         (owner),
    .busy          (busy)
  );

  function automatic logic [DW-1:0] pdata(input int unsigned i, input int unsigned s);
    return 8'(32'hA0 + 16 * i + s);
  endfunction

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = pdata(i, seq[i]);
  end

  // 16-deep FIFO occupancy; full is derived from the registered count
  assign w_full = use_model ? (fcnt == DEPTH) : full_drv;
  always @(posedge clk) begin
    if (rst) fcnt <= 0;
    else if (wr && !w_full && !(rd && fcnt != 0)) fcnt <= fcnt + 1;
    else if (!(wr && !w_full) && rd && fcnt != 0) fcnt <= fcnt - 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int unsigned idx, input int unsigned n);
    beat_t b;
    for (int unsigned j = 0; j < n; j++) begin
      b.idx  = idx;
      b.data = pdata(idx, pseq[idx]);
      pseq[idx]++;
      exp_q.push_back(b);
    end
  endtask

  task automatic sample();
    beat_t e;
    @(negedge clk);
    acked = -1;
    chk("ack_onehot0", 32'($onehot0(ack)), 1);
    chk("write_while_full", 32'(wr & w_full), 0);
    if (wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(wr), 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_ack", 32'(ack), 32'(1) << e.idx);
        chk("beat_data", 32'(din), 32'(e.data));
      end
      for (int i = 0; i < NREQ; i++) if (ack[i]) acked = i;
    end else begin
      chk("idle_ack", 32'(ack), 0);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (acked >= 0) seq[acked]++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '1; full_drv = 1'b0; use_model = 1'b0; rd = 1'b0;
    sample();
    advance();
    sample();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(din), 0);
    advance();
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < NREQ; i++) begin
      seq[i]  = 0;
      pseq[i] = 0;
    end
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy_after", 32'(busy), 0);
  endtask

  initial begin
    // 1: single requester streaming, re-grant after every 4 beats
    do_reset();
    req = 4'b0001;
    push(0, 10);
    for (int c = 0; c < 10; c++) begin
      sample();
      chk("t1_wr", 32'(wr), 1);
      chk("t1_busy", 32'(c % 4 != 0), 32'(busy) ^ 32'(0));
      advance();
    end
    chk("t1_q_empty", 32'(exp_q.size()), 0);

    // 2: all requesting, bursts of 4 in rotation
    do_reset();
    req = 4'b1111;
    push(0, 4); push(1, 4); push(2, 4); push(3, 4); push(0, 1);
    tick(17);
    chk("t2_q_empty", 32'(exp_q.size()), 0);
    chk("t2_owner", 32'(owner), 0);

    // 3: owner 2 stalls on full after beat 2, keeps ownership
    do_reset();
    req = 4'b1100;
    push(2, 4); push(3, 1);
    tick(2);
    full_drv = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("t3_stall_wr", 32'(wr), 0);
      chk("t3_busy", 32'(busy), 1);
      chk("t3_owner", 32'(owner), 2);
      advance();
    end
    full_drv = 1'b0;
    tick(3);
    chk("t3_q_empty", 32'(exp_q.size()), 0);
    chk("t3_rot_owner", 32'(owner), 3);

    // 4: owner 1 drops req mid-burst; non-owner requests ignored during burst
    do_reset();
    req = 4'b0010;
    push(1, 2); push(3, 4); push(0, 1);
    tick(1);
    req = 4'b1011;
    tick(1);
    req = 4'b1001;
    sample();
    chk("t4_dead_wr", 32'(wr), 0);
    chk("t4_dead_busy", 32'(busy), 1);
    advance();
    tick(5);
    chk("t4_q_empty", 32'(exp_q.size()), 0);

    // 5: reset in the middle of owner 3's burst
    do_reset();
    req = 4'b1000;
    push(3, 2);
    tick(2);
    rst = 1'b1;
    sample();
    chk("t5_rst_wr", 32'(wr), 0);
    chk("t5_rst_data", 32'(din), 0);
    advance();
    rst = 1'b0;
    req = 4'b1010;
    chk("t5_busy_after", 32'(busy), 0);
    chk("t5_owner_rst", 32'(owner), 0);
    push(1, 2);
    tick(1);
    chk("t5_owner", 32'(owner), 1);
    tick(1);
    chk("t5_q_empty", 32'(exp_q.size()), 0);

    // 6: fill the 16-deep FIFO, then one read admits exactly one write
    do_reset();
    use_model = 1'b1;
    req = 4'b1111;
    push(0, 4); push(1, 4); push(2, 4); push(3, 4);
    tick(20);
    chk("t6_q_empty", 32'(exp_q.size()), 0);
    chk("t6_full", 32'(w_full), 1);
    chk("t6_count", fcnt, DEPTH);
    rd = 1'b1;
    sample();
    chk("t6_read_cycle_wr", 32'(wr), 0);
    advance();
    rd = 1'b0;
    push(0, 1);
    tick(4);
    chk("t6_q_empty2", 32'(exp_q.size()), 0);
    chk("t6_count2", fcnt, DEPTH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
